mmio_fifo_q: RTL and testbench
==============================

// Module: mmio_fifo_q
// PURPOSE
//  Parametrised successor to the single-port MMIO push buffer used behind the AFU user register.
//  Circular-buffer FIFO with independent push/pop, occupancy count, threshold and sticky error flags.
//  MODE selects true queue (pop-driven) or legacy delay-line (push shifts, output = DEPTH pushes ago).
//  Sits between AFU MMIO write decode (push) and MMIO read decode (pop / dout).
// PARAMETERS
//  WIDTH      64         data width in bits (>=1)
//  DEPTH      8          entries; power of two, >=2
//  AF_THRESH  DEPTH-2    almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  MODE       1          1 = queue (FWFT), 0 = legacy delay line
// PORTS
//  clk          in   1                 single clock, all logic on posedge
//  rst_n        in   1                 async active-low reset
//  push         in   1                 write din this cycle
//  din          in   WIDTH             write data
//  pop          in   1                 consume head entry (ignored in MODE 0)
//  dout         out  WIDTH             head entry (MODE 1) / oldest stage (MODE 0)
//  count        out  $clog2(DEPTH)+1   occupancy, 0..DEPTH
//  empty        out  1                 count == 0
//  full         out  1                 count == DEPTH
//  almost_full  out  1                 count >= AF_THRESH
//  overflow     out  1                 sticky: push while full without pop (MODE 1 only)
//  underflow    out  1                 sticky: pop while empty (MODE 1 only)
//  clr_err      in   1                 sync clear of overflow/underflow
// BEHAVIOUR
//  Clocking and reset: one clock domain. rst_n is asynchronous, active-low.
//  Reset: storage, pointers and count = 0; dout = 0; empty = 1; full, almost_full, overflow, underflow = 0.
//  Status outputs (empty/full/almost_full) derive combinationally from the registered count.
//  MODE 1 (queue):
//   - Pointers wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   - Accepted push: mem[wr_ptr] <= din, wr_ptr++. Accepted pop: rd_ptr++.
//   - First-word fall-through: dout = mem[rd_ptr] when !empty, else 0.
//   - Write-to-dout latency: 1 cycle (no same-cycle bypass).
//   - push && !full: accepted. push && full && !pop: dropped, overflow <= 1, contents unchanged.
//   - push && pop && full: both accepted, count unchanged; the new data lands in the freed slot.
//   - pop && !empty: accepted. pop && empty: ignored, underflow <= 1.
//   - push && pop && empty: push only; count -> 1, underflow <= 1.
//   - count: +1 on push-only accept, -1 on pop-only accept, unchanged on both or neither.
//   - clr_err clears both sticky flags; a new error in the same cycle wins (flag stays 1).
//  MODE 0 (delay line, legacy-compatible):
//   - push: stage[0] <= din, stage[i] <= stage[i-1]; dout = stage[DEPTH-1] (registered, 0 after reset).
//   - pop ignored. count saturates at DEPTH; full = 1 once DEPTH pushes have occurred.
//   - overflow and underflow are held at 0.
//  Reset mid-operation: immediate return to reset state; all data discarded; no partial update.
// TESTING
//  T1 MODE1: reset -> empty=1, count=0, dout=0; push 0xA1,0xA2,0xA3 -> count=3, dout=0xA1 one cycle after first push.
//  T2 MODE1 fill/wrap: 8 pushes 0x10..0x17 -> full=1, almost_full at count 6.
//                      Pop 3, push 0x18..0x1A, pop 8 -> out 0x13..0x1A in order, then empty=1.
//  T3 MODE1 errors: push when full -> overflow=1, count=8, head unchanged.
//                   Pop when empty -> underflow=1; clr_err + overflow event same cycle -> overflow stays 1.
//  T4 MODE1 simultaneous: full + push&pop of 0x55 -> count=8, 0x55 is the 8th value popped.
//                         Empty + push&pop -> count=1, underflow=1.
//  T5 MODE0: push 1..8 -> dout=0 until 8th push, then dout=1; 9th push 9 -> dout=2; pop has no effect.
//  T6 Reset mid-fill: after 5 pushes assert rst_n=0 async between edges -> outputs return to reset values at once.

Source files
------------

// File: rtl/mmio_fifo_q.sv
// MMIO push buffer: circular-buffer FIFO (MODE 1, first-word fall-through) or
// legacy fixed-length delay line (MODE 0), with occupancy and sticky error flags.
module mmio_fifo_q #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int MODE      = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count_reg;

  assign count       = count_reg;
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CW'(DEPTH));
  assign almost_full = (count_reg >= CW'(AF_THRESH));

  generate
    if (MODE == 1) begin : g_queue
      logic [WIDTH-1:0] mem_reg [DEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic             overflow_reg;
      logic             underflow_reg;
      logic             do_push;
      logic             do_pop;
      logic             ovf_evt;
      logic             unf_evt;
      logic [CW-1:0]    count_next;

      // A pop frees the head slot first, so a push into a full queue is
      // accepted whenever it is paired with a pop.
      always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        ovf_evt  = push && full && !pop;
        unf_evt  = pop && empty;
        count_next = count_reg;
        case ({do_push, do_pop})
          2'b10:   count_next = count_reg + 1'b1;
          2'b01:   count_next = count_reg - 1'b1;
          default: count_next = count_reg;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (do_push) begin
          mem_reg[wr_ptr_reg] <= din;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg    <= '0;
          rd_ptr_reg    <= '0;
          count_reg     <= '0;
          overflow_reg  <= 1'b0;
          underflow_reg <= 1'b0;
        end else begin
          if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg     <= count_next;
          // A new error in the clearing cycle keeps the flag set.
          overflow_reg  <= ovf_evt || (overflow_reg && !clr_err);
          underflow_reg <= unf_evt || (underflow_reg && !clr_err);
        end
      end

      assign dout      = empty ? '0 : mem_reg[rd_ptr_reg];
      assign overflow  = overflow_reg;
      assign underflow = underflow_reg;

    end else begin : g_delay
      logic [WIDTH-1:0] stage_reg  [DEPTH];
      logic [WIDTH-1:0] stage_next [DEPTH];

      assign stage_next[0] = din;
      for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
        assign stage_next[gi] = stage_reg[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
          count_reg <= '0;
        end else if (push) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= stage_next[i];
          if (count_reg != CW'(DEPTH)) count_reg <= count_reg + 1'b1;
        end
      end

      assign dout      = stage_reg[DEPTH-1];
      assign overflow  = 1'b0;
      assign underflow = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mmio_fifo_q.sv
// Randomised and directed check of mmio_fifo_q in both modes against a
// queue-based behavioural model.
module tb_mmio_fifo_q;
  localparam int W  = 64;
  localparam int D  = 8;
  localparam int AF = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0] q_dout, d_dout;
  logic [3:0]   q_count, d_count;
  logic         q_empty, q_full, q_af, q_ovf, q_unf;
  logic         d_empty, d_full, d_af, d_ovf, d_unf;

  mmio_fifo_q #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .MODE(1)) u_q (
    .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop),
    .dout(q_dout), .count(q_count), .empty(q_empty), .full(q_full),
    .almost_full(q_af), .overflow(q_ovf), .underflow(q_unf), .clr_err(clr_err)
  );

  mmio_fifo_q #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .MODE(0)) u_d (
    .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop),
    .dout(d_dout), .count(d_count), .empty(d_empty), .full(d_full),
    .almost_full(d_af), .overflow(d_ovf), .underflow(d_unf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue contents for MODE 1, last D pushes for MODE 0.
  logic [W-1:0] mq[$];
  logic [W-1:0] mh[$];
  bit           m_ovf, m_unf;
  int           m_n;
  bit           m_popped, m_pushok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mh.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      m_n      = mq.size();
      m_popped = pop && (m_n > 0);
      m_pushok = push && ((m_n < D) || m_popped);
      m_ovf    = (push && m_n == D && !pop) || (m_ovf && !clr_err);
      m_unf    = (pop && m_n == 0) || (m_unf && !clr_err);
      if (m_popped) void'(mq.pop_front());
      if (m_pushok) mq.push_back(din);
      if (push) begin
        mh.push_back(din);
        if (mh.size() > D) void'(mh.pop_front());
      end
    end
  end

  logic [W-1:0] exp_q_dout, exp_d_dout;
  always @(negedge clk) begin
    exp_q_dout = (mq.size() > 0) ? mq[0] : '0;
    exp_d_dout = (mh.size() == D) ? mh[0] : '0;
    chk("q_dout",  q_dout,  exp_q_dout);
    chk("q_count", 64'(q_count), 64'(mq.size()));
    chk("q_empty", 64'(q_empty), 64'(mq.size() == 0));
    chk("q_full",  64'(q_full),  64'(mq.size() == D));
    chk("q_af",    64'(q_af),    64'(mq.size() >= AF));
    chk("q_ovf",   64'(q_ovf),   64'(m_ovf));
    chk("q_unf",   64'(q_unf),   64'(m_unf));
    chk("d_dout",  d_dout,  exp_d_dout);
    chk("d_count", 64'(d_count), 64'(mh.size()));
    chk("d_full",  64'(d_full),  64'(mh.size() == D));
    chk("d_empty", 64'(d_empty), 64'(mh.size() == 0));
    chk("d_errs",  64'({d_ovf, d_unf}), 64'(0));
  end

  task automatic cyc(input bit p, input logic [W-1:0] d, input bit o, input bit c);
    push = p; din = d; pop = o; clr_err = c;
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    cyc(0, '0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    // T1
    chk("t1 rst count", 64'(q_count), 64'd0);
    chk("t1 rst empty", 64'(q_empty), 64'd1);
    chk("t1 rst dout",  q_dout, 64'd0);
    rst_n = 1'b1;
    cyc(1, 64'hA1, 0, 0);
    chk("t1 fwft dout", q_dout, 64'hA1);
    cyc(1, 64'hA2, 0, 0);
    cyc(1, 64'hA3, 0, 0);
    chk("t1 count3", 64'(q_count), 64'd3);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
    chk("t1 empty", 64'(q_empty), 64'd1);

    // T2
    for (int i = 0; i < 8; i++) begin
      cyc(1, 64'h10 + 64'(i), 0, 0);
      chk("t2 af", 64'(q_af), 64'(i + 1 >= 6));
    end
    chk("t2 full", 64'(q_full), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t2 pop a", q_dout, 64'h10 + 64'(i));
      cyc(0, '0, 1, 0);
    end
    for (int i = 0; i < 3; i++) cyc(1, 64'h18 + 64'(i), 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t2 pop b", q_dout, 64'h13 + 64'(i));
      cyc(0, '0, 1, 0);
    end
    chk("t2 empty", 64'(q_empty), 64'd1);

    // T3
    for (int i = 0; i < 8; i++) cyc(1, 64'h20 + 64'(i), 0, 0);
    cyc(1, 64'h99, 0, 0);
    chk("t3 ovf", 64'(q_ovf), 64'd1);
    chk("t3 count", 64'(q_count), 64'd8);
    chk("t3 head", q_dout, 64'h20);
    cyc(0, '0, 0, 1);
    chk("t3 clr", 64'(q_ovf), 64'd0);
    cyc(1, 64'h98, 0, 1);
    chk("t3 err wins", 64'(q_ovf), 64'd1);
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t3 drain", q_dout, 64'h20 + 64'(i));
      cyc(0, '0, 1, 0);
    end
    cyc(0, '0, 1, 0);
    chk("t3 unf", 64'(q_unf), 64'd1);
    cyc(0, '0, 0, 1);
    chk("t3 unf clr", 64'(q_unf), 64'd0);

    // T4
    for (int i = 0; i < 8; i++) cyc(1, 64'h30 + 64'(i), 0, 0);
    cyc(1, 64'h55, 1, 0);
    chk("t4 count", 64'(q_count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t4 pop", q_dout, (i == 7) ? 64'h55 : 64'h31 + 64'(i));
      cyc(0, '0, 1, 0);
    end
    cyc(1, 64'h66, 1, 0);
    chk("t4 empty pp count", 64'(q_count), 64'd1);
    chk("t4 empty pp unf", 64'(q_unf), 64'd1);
    chk("t4 empty pp dout", q_dout, 64'h66);
    cyc(0, '0, 1, 1);

    // T5
    reset_pulse();
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 64'(i), 0, 0);
      chk("t5 dout", d_dout, (i == 8) ? 64'd1 : 64'd0);
      chk("t5 count", 64'(d_count), 64'(i));
    end
    cyc(1, 64'd9, 0, 0);
    chk("t5 9th", d_dout, 64'd2);
    chk("t5 full", 64'(d_full), 64'd1);
    cyc(0, '0, 1, 0);
    chk("t5 pop ign", d_dout, 64'd2);
    chk("t5 pop cnt", 64'(d_count), 64'd8);

    // T6
    reset_pulse();
    for (int i = 0; i < 5; i++) cyc(1, 64'h40 + 64'(i), 0, 0);
    chk("t6 count5", 64'(q_count), 64'd5);
    push = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 q_count", 64'(q_count), 64'd0);
    chk("t6 q_empty", 64'(q_empty), 64'd1);
    chk("t6 q_dout",  q_dout, 64'd0);
    chk("t6 d_count", 64'(d_count), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Random phases: push-heavy, pop-heavy, balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < 700; k++) begin
        bit p, o, c;
        p = ($urandom_range(99, 0) < ((ph == 0) ? 75 : (ph == 1) ? 25 : 50));
        o = ($urandom_range(99, 0) < ((ph == 0) ? 25 : (ph == 1) ? 75 : 50));
        c = ($urandom_range(99, 0) < 5);
        cyc(p, {$urandom, $urandom}, o, c);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
